// File: rtl/sample_msg_splitter_buf.sv
// Splits samples (MSB=0) from length-prefixed messages; messages are buffered whole and released on commit.
// Latency: samples 1 cycle; a message becomes valid the cycle after its final word is written. Input has no backpressure; out_msg is valid/ready.
// Option: define SAMPLE_MSG_SPLITTER_STATS_EN to add the saturating msg_drop_count port.
module sample_msg_splitter_buf #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 8,
    parameter int MSG_DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_nd,
    output logic [WIDTH-1:0] out_samples,
    output logic             out_samples_nd,
    output logic [WIDTH-1:0] out_msg,
    output logic             out_msg_last,
    output logic             out_msg_valid,
    input  logic             out_msg_ready,
    input  logic             err_clr,
`ifdef SAMPLE_MSG_SPLITTER_STATS_EN
    output logic [15:0]      msg_drop_count,
`endif
    output logic [1:0]       error
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (LEN_WIDTH + 1 > PW + 1) ? LEN_WIDTH + 1 : PW + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d, commit_q, commit_d;
    logic [WIDTH-1:0]     samp_q, samp_d;
    logic                 samp_nd_q, samp_nd_d;
    logic [1:0]           error_q, error_d;
    logic [WIDTH:0]       mem_q [MSG_DEPTH];

    logic                 we;
    logic [AW-1:0]        waddr;
    logic [WIDTH:0]       wdat;
    logic [PW-1:0]        base, used;
    logic [CW-1:0]        need, free;
    logic [1:0]           err_set;
    logic                 abort, drop;
    logic                 is_hdr;
    logic [LEN_WIDTH-1:0] len;

    assign is_hdr = in_data[WIDTH-1];
    assign len    = in_data[WIDTH-2 -: LEN_WIDTH];
    // free space counts only committed-unread words; a same-cycle pop is not credited
    assign used   = commit_q - rd_q;
    assign free   = CW'(MSG_DEPTH) - CW'(used);
    assign need   = CW'(len) + CW'(1);

    assign out_msg_valid  = (rd_q != commit_q);
    assign out_msg        = mem_q[rd_q[AW-1:0]][WIDTH-1:0];
    assign out_msg_last   = mem_q[rd_q[AW-1:0]][WIDTH];
    assign out_samples    = samp_q;
    assign out_samples_nd = samp_nd_q;
    assign error          = error_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wr_d      = wr_q;
        commit_d  = commit_q;
        samp_d    = samp_q;
        samp_nd_d = 1'b0;
        err_set   = 2'b00;
        abort     = 1'b0;
        drop      = 1'b0;
        we        = 1'b0;
        waddr     = wr_q[AW-1:0];
        wdat      = {1'b0, in_data};
        base      = wr_q;
        if (in_nd) begin
            if (is_hdr) begin
                if (state_q != IDLE) err_set[0] = 1'b1;
                if (state_q == COLLECT) begin
                    base  = commit_q;
                    abort = 1'b1;
                end
                if (need <= free) begin
                    we    = 1'b1;
                    waddr = base[AW-1:0];
                    wdat  = {(len == '0), in_data};
                    wr_d  = base + PW'(1);
                    rem_d = len;
                    if (len == '0) begin
                        commit_d = base + PW'(1);
                        state_d  = IDLE;
                    end else begin
                        state_d  = COLLECT;
                    end
                end else begin
                    err_set[1] = 1'b1;
                    drop       = 1'b1;
                    wr_d       = base;
                    rem_d      = len;
                    state_d    = (len == '0) ? IDLE : DROP;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        samp_d    = in_data;
                        samp_nd_d = 1'b1;
                    end
                    COLLECT: begin
                        we    = 1'b1;
                        wdat  = {(rem_q == LEN_WIDTH'(1)), in_data};
                        wr_d  = wr_q + PW'(1);
                        rem_d = rem_q - LEN_WIDTH'(1);
                        if (rem_q == LEN_WIDTH'(1)) begin
                            commit_d = wr_q + PW'(1);
                            state_d  = IDLE;
                        end
                    end
                    default: begin
                        rem_d = rem_q - LEN_WIDTH'(1);
                        if (rem_q == LEN_WIDTH'(1)) state_d = IDLE;
                    end
                endcase
            end
        end
        rd_d    = rd_q + PW'(out_msg_valid && out_msg_ready);
        error_d = err_clr ? 2'b00 : (error_q | err_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            commit_q  <= '0;
            samp_q    <= '0;
            samp_nd_q <= 1'b0;
            error_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            commit_q  <= commit_d;
            samp_q    <= samp_d;
            samp_nd_q <= samp_nd_d;
            error_q   <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdat;
    end

`ifdef SAMPLE_MSG_SPLITTER_STATS_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    assign cnt_sum        = {1'b0, cnt_q} + 17'(abort) + 17'(drop);
    assign cnt_d          = err_clr ? 16'd0 : (cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0]);
    assign msg_drop_count = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_sample_msg_splitter_buf.sv
// Randomized scoreboard bench for sample_msg_splitter_buf with an 8-word message buffer.
module tb_sample_msg_splitter_buf;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_nd;
    logic [31:0] out_samples;
    logic        out_samples_nd;
    logic [31:0] out_msg;
    logic        out_msg_last;
    logic        out_msg_valid;
    logic        out_msg_ready;
    logic        err_clr;
    logic [1:0]  error;
`ifdef SAMPLE_MSG_SPLITTER_STATS_EN
    logic [15:0] msg_drop_count;
`endif

    always #5 clk = ~clk;

    sample_msg_splitter_buf #(.WIDTH(32), .LEN_WIDTH(8), .MSG_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_nd          (in_nd),
        .out_samples    (out_samples),
        .out_samples_nd (out_samples_nd),
        .out_msg        (out_msg),
        .out_msg_last   (out_msg_last),
        .out_msg_valid  (out_msg_valid),
        .out_msg_ready  (out_msg_ready),
        .err_clr        (err_clr),
`ifdef SAMPLE_MSG_SPLITTER_STATS_EN
        .msg_drop_count (msg_drop_count),
`endif
        .error          (error)
    );

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    logic [32:0] exp_msg[$];
    logic [31:0] exp_samp[$];

    // Message-level reference: state 0 idle, 1 collecting, 2 dropping
    int          m_st, m_rem, m_avail, m_cnt;
    logic [32:0] m_part[$];
    logic [1:0]  m_err;
    logic        m_snd;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] hdr(input int l);
        logic [31:0] v;
        v = 32'h8000_0000;
        v[30:23] = l[7:0];
        return v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_rem = 0; m_avail = 0; m_cnt = 0; m_err = 2'b00; m_snd = 1'b0;
        m_part.delete();
        exp_msg.delete();
        exp_samp.delete();
    endtask

    // Applies one clock edge to the model using the inputs currently driven
    task automatic model_edge();
        int newc;
        int pop;
        int l;
        newc = 0;
        pop  = (m_avail > 0 && out_msg_ready) ? 1 : 0;
        l    = int'(in_data[30:23]);
        m_snd = 1'b0;
        if (in_nd) begin
            if (in_data[31]) begin
                if (m_st != 0) m_err[0] = 1'b1;
                if (m_st == 1) begin
                    m_part.delete();
                    m_cnt++;
                end
                if (l + 1 <= DEPTH - m_avail) begin
                    m_part.delete();
                    m_part.push_back({(l == 0), in_data});
                    if (l == 0) begin
                        foreach (m_part[k]) exp_msg.push_back(m_part[k]);
                        newc = m_part.size();
                        m_part.delete();
                        m_st = 0;
                    end else begin
                        m_st = 1;
                        m_rem = l;
                    end
                end else begin
                    m_err[1] = 1'b1;
                    m_cnt++;
                    m_st = (l == 0) ? 0 : 2;
                    m_rem = l;
                end
            end else begin
                case (m_st)
                    0: begin
                        m_snd = 1'b1;
                        exp_samp.push_back(in_data);
                    end
                    1: begin
                        m_part.push_back({(m_rem == 1), in_data});
                        m_rem--;
                        if (m_rem == 0) begin
                            foreach (m_part[k]) exp_msg.push_back(m_part[k]);
                            newc = m_part.size();
                            m_part.delete();
                            m_st = 0;
                        end
                    end
                    default: begin
                        m_rem--;
                        if (m_rem == 0) m_st = 0;
                    end
                endcase
            end
        end
        m_avail = m_avail - pop + newc;
        if (m_cnt > 65535) m_cnt = 65535;
        if (err_clr) begin
            m_err = 2'b00;
            m_cnt = 0;
        end
    endtask

    task automatic cyc(input logic nd, input logic [31:0] d, input logic rdy, input logic clr);
        in_nd = nd; in_data = d; out_msg_ready = rdy; err_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        in_nd = 1'b0; in_data = '0; out_msg_ready = 1'b0; err_clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_samples", 64'(out_samples), 64'd0);
        chk("rst_samples_nd", 64'(out_samples_nd), 64'd0);
        chk("rst_msg_valid", 64'(out_msg_valid), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
`ifdef SAMPLE_MSG_SPLITTER_STATS_EN
        chk("rst_drop_count", 64'(msg_drop_count), 64'd0);
`endif
        rst_n = 1'b1;
        #1;
        mon_en = 1'b1;
    endtask

    // Monitor: outputs sampled on the falling edge, popping the scoreboard on each handshake
    always @(negedge clk) begin
        if (mon_en) begin
            chk("samples_nd", 64'(out_samples_nd), 64'(m_snd));
            if (out_samples_nd) begin
                if (exp_samp.size() == 0) chk("sample_unexpected", 64'(out_samples), 64'hDEAD);
                else chk("sample_data", 64'(out_samples), 64'(exp_samp.pop_front()));
            end
            chk("msg_valid", 64'(out_msg_valid), 64'(m_avail > 0));
            if (out_msg_valid && out_msg_ready) begin
                if (exp_msg.size() == 0) chk("msg_unexpected", 64'({out_msg_last, out_msg}), 64'hDEAD);
                else chk("msg_word", 64'({out_msg_last, out_msg}), 64'(exp_msg.pop_front()));
            end
            chk("error", 64'(error), 64'(m_err));
`ifdef SAMPLE_MSG_SPLITTER_STATS_EN
            chk("drop_count", 64'(msg_drop_count), 64'(m_cnt));
`endif
        end
    end

    int rmode;
    logic rdy, nd, clr;
    logic [31:0] d;

    initial begin
        rst_n = 1'b1;
        do_reset();

        // two plain samples
        cyc(1, 32'h1, 1, 0);
        cyc(1, 32'h2, 1, 0);
        cyc(0, 32'h0, 1, 0);
        // whole message, consumer ready
        cyc(1, hdr(2), 1, 0);
        cyc(1, 32'hA, 1, 0);
        cyc(1, 32'hB, 1, 0);
        repeat (4) cyc(0, 32'h0, 1, 0);
        // truncated message aborted by an empty header
        cyc(1, hdr(3), 1, 0);
        cyc(1, 32'hC, 1, 0);
        cyc(1, hdr(0), 1, 0);
        repeat (3) cyc(0, 32'h0, 1, 0);
        cyc(0, 32'h0, 1, 1);
        // overflow: second message dropped while consumer stalls
        cyc(1, hdr(4), 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'h10 + i, 0, 0);
        cyc(1, hdr(3), 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h20 + i, 0, 0);
        repeat (8) cyc(0, 32'h0, 1, 0);
        // oversized message always dropped
        cyc(1, hdr(DEPTH), 1, 0);
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h30 + i, 1, 0);
        // sample interleaved with a message under toggling ready
        cyc(1, hdr(1), 0, 0);
        cyc(1, 32'h5, 1, 0);
        cyc(1, 32'h7, 0, 0);
        cyc(0, 32'h0, 1, 0);
        cyc(0, 32'h0, 0, 0);
        repeat (3) cyc(0, 32'h0, 1, 0);
        cyc(0, 32'h0, 1, 1);

        rmode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) rmode = $urandom_range(0, 2);
            rdy = (rmode == 0) ? ($urandom_range(0, 7) == 0) :
                  (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            nd  = ($urandom_range(0, 4) != 0);
            d   = ($urandom_range(0, 5) == 0) ? hdr($urandom_range(0, 9)) : ($urandom & 32'h7FFF_FFFF);
            clr = ($urandom_range(0, 199) == 0);
            cyc(nd, d, rdy, clr);
            if (i == 1500) do_reset();
        end

        repeat (30) cyc(0, 32'h0, 1, 0);
        @(negedge clk);
        mon_en = 1'b0;
        chk("leftover_msgs", 64'(exp_msg.size()), 64'd0);
        chk("leftover_samples", 64'(exp_samp.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
